// File: rtl/reg_op_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared constants and FSM encoding for the two-requester op-register sequencer.
// Each request replays its op for cnt+1 cycles, then done pulses; requests are held off while busy.
package reg_op_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 4;
  localparam int OP_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/reg_op_sequencer_if.sv
`timescale 1ns/1ps
// Request and register-side bundle; master = requesters + register, slave = reg_op_sequencer.
// Requests are held by valid until ready; the register side has no flow control.
interface reg_op_sequencer_if #(
  parameter int WIDTH = reg_op_pkg::DEF_WIDTH,
  parameter int CNT_W = reg_op_pkg::DEF_CNT_W
);
  import reg_op_pkg::*;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*OP_W-1:0]   req_op;
  logic [1:0]          req_load;
  logic [2*WIDTH-1:0]  req_data;
  logic [2*CNT_W-1:0]  req_cnt;
  logic [1:0]          done;
  logic                busy;
  logic                load;
  logic [OP_W-1:0]     s;
  logic [WIDTH-1:0]    reg_in;
  logic [WIDTH-1:0]    reg_out;
  logic [WIDTH-1:0]    rsp_data;

  modport master (
    output req_valid, req_op, req_load, req_data, req_cnt, reg_out,
    input  req_ready, done, busy, load, s, reg_in, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_load, req_data, req_cnt, reg_out,
    output req_ready, done, busy, load, s, reg_in, rsp_data
  );
endinterface

// File: rtl/reg_op_sequencer_arb.sv
`timescale 1ns/1ps
// rr_arbiter2: combinational 2-way grant from valid and a pointer; zero latency.
// Pointer moves to the other requester on each accept, so a held-off loser wins next time.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);
  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = ~grant_o[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/reg_op_sequencer.sv
`timescale 1ns/1ps
// Shares the op register between two requesters: accept -> cnt+1 EXEC cycles -> 1-cycle done; ready only in IDLE.
// REG_OP_SEQ_CAPTURE_EN adds rsp_data capture of reg_out in the DONE cycle; otherwise rsp_data is 0.
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic               clk,
  input logic               reset,
  reg_op_sequencer_if.slave bus
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              ld_q, ld_d;
  logic              first_q, first_d;
  logic              owner_q, owner_d;

  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              accept;
  logic              gidx;

  logic              load_c;
  logic [OP_W-1:0]   s_c;
  logic [WIDTH-1:0]  reg_in_c;
  logic [1:0]        done_c;
  logic              busy_c;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (bus.req_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  // Gated by reset so ready is low while reset is held, not just after the next edge.
  assign ready  = grant & {2{(state_q == ST_IDLE) && !reset}};
  assign accept = |ready;
  assign gidx   = grant[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    data_d   = data_q;
    ld_d     = ld_q;
    first_d  = first_q;
    owner_d  = owner_q;
    load_c   = 1'b0;
    s_c      = '0;
    reg_in_c = '0;
    done_c   = 2'b00;
    busy_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = gidx ? bus.req_op[2*OP_W-1:OP_W]     : bus.req_op[OP_W-1:0];
          data_d  = gidx ? bus.req_data[2*WIDTH-1:WIDTH] : bus.req_data[WIDTH-1:0];
          cnt_d   = gidx ? bus.req_cnt[2*CNT_W-1:CNT_W]  : bus.req_cnt[CNT_W-1:0];
          ld_d    = bus.req_load[gidx];
          owner_d = gidx;
          first_d = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy_c   = 1'b1;
        s_c      = op_q;
        reg_in_c = data_q;
        load_c   = ld_q & first_q;
        first_d  = 1'b0;
        // Exit on zero rather than decrementing past it, so cnt=all-ones never wraps.
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        busy_c          = 1'b1;
        done_c[owner_q] = 1'b1;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      ld_q    <= 1'b0;
      first_q <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      ld_q    <= ld_d;
      first_q <= first_d;
      owner_q <= owner_d;
    end
  end

`ifdef REG_OP_SEQ_CAPTURE_EN
  logic [WIDTH-1:0] rsp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   rsp_q <= '0;
    else if (state_q == ST_DONE) rsp_q <= bus.reg_out;
  end

  assign bus.rsp_data = rsp_q;
`else
  assign bus.rsp_data = '0;
`endif

  assign bus.req_ready = ready;
  assign bus.load      = load_c;
  assign bus.s         = s_c;
  assign bus.reg_in    = reg_in_c;
  assign bus.done      = done_c;
  assign bus.busy      = busy_c;
endmodule

// File: tb/tb_reg_op_sequencer.sv
`timescale 1ns/1ps
// Bench for reg_op_sequencer: directed table, multi-cycle corner sequences and random traffic
// checked every cycle against a transaction-schedule reference model.
module tb_reg_op_sequencer;
  localparam int W  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;

  reg_op_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  reg_op_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: an accept at sample t owns the register for t+1..t+1+cnt,
  // pulses done at t+2+cnt and frees the block from t+3+cnt.
  int          cyc    = 0;
  int          m_acc  = -1000;
  int          m_cnt  = 0;
  int          m_free = 0;
  int          m_gi;
  logic        m_ptr  = 1'b0;
  logic [1:0]  m_op;
  logic [3:0]  m_dat;
  logic        m_ld;
  int          m_own;
  logic [3:0]  m_rsp  = '0;
  logic [1:0]  e_rdy, e_done, e_s;
  logic [3:0]  e_in;
  logic        e_load, e_busy;

  logic [1:0]  hs_seen = '0;
  int          exec_n = 0, load_n = 0, done_n = 0;
  int          done_cyc [2];
  logic [1:0]  last_done = '0;
  logic [1:0]  first_s;
  logic [3:0]  first_in;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready",  bus.req_ready, 0);
      chk("rst_busy",   bus.busy, 0);
      chk("rst_done",   bus.done, 0);
      chk("rst_load",   bus.load, 0);
      chk("rst_s",      bus.s, 0);
      chk("rst_reg_in", bus.reg_in, 0);
      chk("rst_rsp",    bus.rsp_data, 0);
      m_acc = -1000; m_cnt = 0; m_free = 0; m_ptr = 1'b0; m_rsp = '0; hs_seen = '0;
    end else begin
      e_load = 1'b0; e_s = '0; e_in = '0; e_busy = 1'b0; e_done = '0; e_rdy = '0;
      if (cyc >= m_acc + 1 && cyc <= m_acc + 1 + m_cnt) begin
        e_s = m_op; e_in = m_dat; e_busy = 1'b1;
        e_load = (cyc == m_acc + 1) ? m_ld : 1'b0;
      end
      if (cyc == m_acc + 2 + m_cnt) begin
        e_done[m_own] = 1'b1; e_busy = 1'b1;
      end
      if (cyc >= m_free) begin
        if (bus.req_valid == 2'b11) e_rdy[m_ptr] = 1'b1;
        else                        e_rdy = bus.req_valid;
      end
      chk("m_ready",  bus.req_ready, e_rdy);
      chk("m_busy",   bus.busy, e_busy);
      chk("m_done",   bus.done, e_done);
      chk("m_load",   bus.load, e_load);
      chk("m_s",      bus.s, e_s);
      chk("m_reg_in", bus.reg_in, e_in);
`ifdef REG_OP_SEQ_CAPTURE_EN
      chk("m_rsp", bus.rsp_data, m_rsp);
      if (e_done != 0) m_rsp = bus.reg_out;
`else
      chk("m_rsp", bus.rsp_data, 0);
`endif
      hs_seen = bus.req_valid & bus.req_ready;
      if (e_rdy != 0) begin
        m_gi   = e_rdy[1] ? 1 : 0;
        m_acc  = cyc;
        m_op   = bus.req_op[2*m_gi +: 2];
        m_dat  = bus.req_data[4*m_gi +: 4];
        m_ld   = bus.req_load[m_gi];
        m_cnt  = int'(bus.req_cnt[4*m_gi +: 4]);
        m_own  = m_gi;
        m_free = cyc + 3 + m_cnt;
        m_ptr  = (m_gi == 0);
      end
      if (bus.busy && bus.done == 0) begin
        if (exec_n == 0) begin first_s = bus.s; first_in = bus.reg_in; end
        exec_n++;
      end
      if (bus.load) load_n++;
      if (bus.done != 0) begin
        done_n++;
        last_done = bus.done;
        done_cyc[bus.done[1] ? 1 : 0] = cyc;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.reg_out = 4'($urandom);
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] d,
                         input logic ld, input logic [3:0] c);
    bus.req_op[2*r +: 2]   = op;
    bus.req_data[4*r +: 4] = d;
    bus.req_cnt[4*r +: 4]  = c;
    bus.req_load[r]        = ld;
    bus.req_valid[r]       = 1'b1;
  endtask

  task automatic wait_hs(input int r, input string nm);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      got = hs_seen[r];
    end
    chk(nm, got, 1);
  endtask

  task automatic wait_done(input string nm);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      step();
      got = (done_n > 0);
    end
    chk(nm, got, 1);
  endtask

  task automatic apply_reset();
    bus.req_valid = 2'b00;
    #1 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         r;
    logic [1:0] op;
    logic [3:0] dat;
    logic       ld;
    logic [3:0] cnt;
    int         exp_exec;
    int         exp_loads;
    logic [1:0] exp_done;
    logic [1:0] exp_s;
    logic [3:0] exp_in;
  } vec_t;

  vec_t tbl [5];
  int   first_g;
  int   gk;
  int   g;
  logic [3:0] rc;

  initial begin
    tbl[0] = '{r:0, op:2'b01, dat:4'h6, ld:1'b1, cnt:4'd0,  exp_exec:1,  exp_loads:1, exp_done:2'b01, exp_s:2'b01, exp_in:4'h6};
    tbl[1] = '{r:1, op:2'b10, dat:4'hB, ld:1'b1, cnt:4'd3,  exp_exec:4,  exp_loads:1, exp_done:2'b10, exp_s:2'b10, exp_in:4'hB};
    tbl[2] = '{r:0, op:2'b11, dat:4'h3, ld:1'b0, cnt:4'd2,  exp_exec:3,  exp_loads:0, exp_done:2'b01, exp_s:2'b11, exp_in:4'h3};
    tbl[3] = '{r:1, op:2'b00, dat:4'hF, ld:1'b1, cnt:4'd15, exp_exec:16, exp_loads:1, exp_done:2'b10, exp_s:2'b00, exp_in:4'hF};
    tbl[4] = '{r:0, op:2'b10, dat:4'hA, ld:1'b1, cnt:4'd15, exp_exec:16, exp_loads:1, exp_done:2'b01, exp_s:2'b10, exp_in:4'hA};

    reset = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.req_load = '0;
    bus.req_data  = '0; bus.req_cnt = '0; bus.reg_out = '0;

    #8;
    chk("t1_load",   bus.load, 0);
    chk("t1_s",      bus.s, 0);
    chk("t1_reg_in", bus.reg_in, 0);
    chk("t1_done",   bus.done, 0);
    chk("t1_busy",   bus.busy, 0);
    chk("t1_ready",  bus.req_ready, 0);
    #4.5 reset = 1'b0;
    @(posedge clk);
    #1;

    // Both valid straight after reset: requester 0 first, done pulses 3 cycles apart.
    done_cyc[0] = -1; done_cyc[1] = -1; first_g = -1;
    set_req(0, 2'b01, 4'h6, 1'b1, 4'd0);
    set_req(1, 2'b10, 4'h9, 1'b0, 4'd0);
    for (int n = 0; n < 20 && bus.req_valid != 0; n++) begin
      step();
      if (hs_seen[0]) begin if (first_g < 0) first_g = 0; bus.req_valid[0] = 1'b0; end
      if (hs_seen[1]) begin if (first_g < 0) first_g = 1; bus.req_valid[1] = 1'b0; end
    end
    chk("t3_first_grant", first_g, 0);
    chk("t3_all_granted", bus.req_valid, 0);
    for (int n = 0; n < 20 && done_cyc[1] < 0; n++) step();
    chk("t3_done_gap", done_cyc[1] - done_cyc[0], 3);

    for (int i = 0; i < 5; i++) begin
      exec_n = 0; load_n = 0; done_n = 0;
      set_req(tbl[i].r, tbl[i].op, tbl[i].dat, tbl[i].ld, tbl[i].cnt);
      wait_hs(tbl[i].r, "tbl_hs");
      bus.req_valid[tbl[i].r] = 1'b0;
      wait_done("tbl_done_seen");
      chk("tbl_exec_cycles", exec_n, tbl[i].exp_exec);
      chk("tbl_load_pulses", load_n, tbl[i].exp_loads);
      chk("tbl_done_owner",  last_done, tbl[i].exp_done);
      chk("tbl_first_s",     first_s, tbl[i].exp_s);
      chk("tbl_first_in",    first_in, tbl[i].exp_in);
    end

    // Reset in the 2nd EXEC cycle of a cnt=3 op abandons it without a done pulse.
    done_n = 0;
    set_req(1, 2'b10, 4'hB, 1'b1, 4'd3);
    wait_hs(1, "t5_hs");
    bus.req_valid[1] = 1'b0;
    step();
    chk("t5_mid_s",    bus.s, 2'b10);
    chk("t5_mid_load", bus.load, 0);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_load",   bus.load, 0);
    chk("t5_rst_s",      bus.s, 0);
    chk("t5_rst_reg_in", bus.reg_in, 0);
    chk("t5_rst_busy",   bus.busy, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (8) step();
    chk("t5_no_done", done_n, 0);
    set_req(0, 2'b11, 4'h5, 1'b1, 4'd1);
    wait_hs(0, "t5_post_hs");
    bus.req_valid[0] = 1'b0;
    wait_done("t5_post_done_seen");
    chk("t5_post_owner", last_done, 2'b01);

    // Both held valid for 6 cnt=0 ops: grants alternate starting from requester 0.
    apply_reset();
    gk = 0;
    set_req(0, 2'($urandom), 4'($urandom), 1'b1, 4'd0);
    set_req(1, 2'($urandom), 4'($urandom), 1'b1, 4'd0);
    for (int n = 0; n < 80 && gk < 6; n++) begin
      step();
      if (hs_seen != 0) begin
        g = hs_seen[1] ? 1 : 0;
        chk("t6_grant_order", g, gk % 2);
        gk++;
        set_req(g, 2'($urandom), 4'($urandom), 1'($urandom), 4'd0);
      end
    end
    bus.req_valid = 2'b00;
    chk("t6_grant_count", gk, 6);
    repeat (4) step();

    for (int k = 0; k < 500; k++) begin
      step();
      for (int r = 0; r < 2; r++) begin
        if (!bus.req_valid[r] || hs_seen[r]) begin
          if ($urandom_range(0, 1) == 1) begin
            rc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            set_req(r, 2'($urandom), 4'($urandom), 1'($urandom), rc);
          end else begin
            bus.req_valid[r] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[r] = 1'b0;
        end
      end
    end
    bus.req_valid = 2'b00;
    repeat (25) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
